// File: rtl/npc_seq_pkg.sv
// Shared state encoding and parameter defaults for the NPC multi-cycle step sequencer.
package npc_seq_pkg;

  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int CNT_W_DEFAULT   = 64;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH_REQ  = 4'd1,
    FETCH_WAIT = 4'd2,
    DECODE     = 4'd3,
    EXEC_START = 4'd4,
    EXEC_WAIT  = 4'd5,
    EXEC       = 4'd6,
    MEM_REQ    = 4'd7,
    MEM_WAIT   = 4'd8,
    WB         = 4'd9,
    HALT       = 4'd10,
    ERR        = 4'd11
  } seq_state_e;

  // States that wait on an external agent and are therefore guarded by the watchdog.
  function automatic logic is_wait_state(input seq_state_e s);
    logic w_s;
    case (s)
      FETCH_REQ, FETCH_WAIT, MEM_REQ, MEM_WAIT, EXEC_WAIT: w_s = 1'b1;
      default:                                             w_s = 1'b0;
    endcase
    return w_s;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Clearable stall counter; flags expiry on the last allowed cycle of a wait state.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit             ENABLED = (TIMEOUT > 0);
  localparam logic [CW-1:0]  LIMIT   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_r;

  // Cycles spent in the current wait state; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && ENABLED && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = ENABLED && en && (cnt_r == LIMIT);

endmodule

// File: rtl/npc_step_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with retire counter,
// ebreak halt and a watchdog that traps stalled handshakes.
module npc_step_sequencer
  import npc_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifetch_valid,
  input  logic             ifetch_ready,
  input  logic             ifetch_rvalid,
  output logic             ir_we,
  input  logic             mem_enable,
  input  logic             mem_is_store,
  input  logic             reg_write_en,
  input  logic             alu_multi,
  input  logic             is_ebreak,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             dmem_valid,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             dmem_rvalid,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_r;
  seq_state_e       state_next_s;
  logic             wd_clr_s;
  logic             wd_en_s;
  logic             wd_expired_s;
  logic             ifetch_valid_r;
  logic             fetch_wait_r;
  logic             alu_start_r;
  logic             dmem_valid_r;
  logic             pc_we_r;
  logic             halted_r;
  logic             bus_err_r;
  logic [CNT_W-1:0] retired_r;

  assign wd_en_s  = is_wait_state(state_r);
  assign wd_clr_s = (state_next_s != state_r);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  // Next-state selection; an exit condition always beats a coincident watchdog expiry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:       state_next_s = FETCH_REQ;
      FETCH_REQ: begin
        if (ifetch_ready)      state_next_s = FETCH_WAIT;
        else if (wd_expired_s) state_next_s = ERR;
        else                   state_next_s = FETCH_REQ;
      end
      FETCH_WAIT: begin
        if (ifetch_rvalid)     state_next_s = DECODE;
        else if (wd_expired_s) state_next_s = ERR;
        else                   state_next_s = FETCH_WAIT;
      end
      DECODE: begin
        if (is_ebreak)         state_next_s = HALT;
        else if (alu_multi)    state_next_s = EXEC_START;
        else                   state_next_s = EXEC;
      end
      EXEC_START: state_next_s = EXEC_WAIT;
      EXEC_WAIT: begin
        if (alu_done)          state_next_s = WB;
        else if (wd_expired_s) state_next_s = ERR;
        else                   state_next_s = EXEC_WAIT;
      end
      EXEC: begin
        if (mem_enable)        state_next_s = MEM_REQ;
        else                   state_next_s = WB;
      end
      MEM_REQ: begin
        if (dmem_ready)        state_next_s = MEM_WAIT;
        else if (wd_expired_s) state_next_s = ERR;
        else                   state_next_s = MEM_REQ;
      end
      MEM_WAIT: begin
        if (dmem_rvalid)       state_next_s = WB;
        else if (wd_expired_s) state_next_s = ERR;
        else                   state_next_s = MEM_WAIT;
      end
      WB:         state_next_s = FETCH_REQ;
      HALT:       state_next_s = HALT;
      ERR:        state_next_s = ERR;
      default:    state_next_s = IDLE;
    endcase
  end

  // State register plus per-state output flags, decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      ifetch_valid_r <= 1'b0;
      fetch_wait_r   <= 1'b0;
      alu_start_r    <= 1'b0;
      dmem_valid_r   <= 1'b0;
      pc_we_r        <= 1'b0;
      halted_r       <= 1'b0;
      bus_err_r      <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      ifetch_valid_r <= (state_next_s == FETCH_REQ);
      fetch_wait_r   <= (state_next_s == FETCH_WAIT);
      alu_start_r    <= (state_next_s == EXEC_START);
      dmem_valid_r   <= (state_next_s == MEM_REQ);
      pc_we_r        <= (state_next_s == WB);
      halted_r       <= (state_next_s == HALT);
      bus_err_r      <= (state_next_s == ERR);
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_r <= '0;
    end else if (state_r == WB) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end

  assign ifetch_valid = ifetch_valid_r;
  assign ir_we        = fetch_wait_r & ifetch_rvalid;
  assign alu_start    = alu_start_r;
  assign dmem_valid   = dmem_valid_r;
  assign dmem_we      = dmem_valid_r & mem_is_store;
  assign pc_we        = pc_we_r;
  assign rf_we        = pc_we_r & reg_write_en;
  assign halted       = halted_r;
  assign bus_err      = bus_err_r;
  assign retired      = retired_r;

endmodule

// File: tb/tb_npc_step_sequencer.sv
// Scoreboard bench: a reactive bus/ALU agent issues randomized instructions and a
// monitor checks each writeback against cycle-accurate expectations from a cost model.
module tb_npc_step_sequencer;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_valid, ifetch_ready, ifetch_rvalid, ir_we;
  logic        mem_enable, mem_is_store, reg_write_en, alu_multi, is_ebreak;
  logic        alu_start, alu_done;
  logic        dmem_valid, dmem_we, dmem_ready, dmem_rvalid;
  logic        pc_we, rf_we, halted, bus_err;
  logic [63:0] retired;

  npc_step_sequencer #(.TIMEOUT(TO), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifetch_valid(ifetch_valid), .ifetch_ready(ifetch_ready), .ifetch_rvalid(ifetch_rvalid),
    .ir_we(ir_we), .mem_enable(mem_enable), .mem_is_store(mem_is_store),
    .reg_write_en(reg_write_en), .alu_multi(alu_multi), .is_ebreak(is_ebreak),
    .alu_start(alu_start), .alu_done(alu_done),
    .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .pc_we(pc_we), .rf_we(rf_we), .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              cyc;
    bit              rf;
    longint unsigned ret;
  } exp_t;

  exp_t            sb[$];
  exp_t            e;
  int              next_start;
  longint unsigned model_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return ifetch_valid;
      1:       return dmem_valid;
      default: return alu_start;
    endcase
  endfunction

  task automatic wait_out(input int w, input string name);
    int n;
    n = 0;
    while (sig(w) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, sig(w), 1'b1);
  endtask

  // Writeback monitor: every pc_we pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_we) begin
        if (sb.size() == 0) begin
          chk("pc_we_unexpected", pc_we, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("wb_cycle", cyc, e.cyc);
          chk("rf_we", rf_we, e.rf);
          chk("retired_at_wb", retired, e.ret);
        end
      end else if (rf_we) begin
        chk("rf_we_outside_wb", rf_we, 1'b0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    {ifetch_ready, ifetch_rvalid, mem_enable, mem_is_store, reg_write_en} = 5'd0;
    {alu_multi, is_ebreak, alu_done, dmem_ready, dmem_rvalid} = 5'd0;
    #1;
    chk("reset_outputs", {ifetch_valid, ir_we, alu_start, dmem_valid, dmem_we,
                          pc_we, rf_we, halted, bus_err}, 9'd0);
    chk("reset_retired", retired, 64'd0);
    sb.delete();
    model_ret = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    next_start = cyc + 1;
    @(negedge clk);
    dmem_rvalid = 1'b1; ifetch_rvalid = 1'b1; alu_done = 1'b1;
    chk("idle_after_reset", ifetch_valid, 1'b0);
    @(negedge clk);
    dmem_rvalid = 1'b0; ifetch_rvalid = 1'b0; alu_done = 1'b0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 multi-cycle, 4 ebreak, 5 stuck store, 6 load aborted by reset
  task automatic run_instr(input int kind, input bit rw, input int fr, input int rv,
                           input int mr, input int mv, input int nmul, input bit spur);
    int len;
    int pc_c;
    int n;
    len = fr + 1 + rv + 1;
    case (kind)
      0:       len += 2;
      1, 2:    len += 1 + mr + 1 + mv + 1;
      3:       len += 1 + nmul + 1;
      default: len += 0;
    endcase
    wait_out(0, "fetch_req");
    chk("fetch_start_cycle", cyc, next_start);
    for (int i = 0; i < fr; i++) begin
      @(negedge clk);
      chk("ifetch_valid_held", ifetch_valid, 1'b1);
    end
    ifetch_ready = 1'b1;
    if (spur) ifetch_rvalid = 1'b1;
    #1 chk("ir_we_before_accept", ir_we, 1'b0);
    @(negedge clk);
    ifetch_ready = 1'b0; ifetch_rvalid = 1'b0;
    chk("ifetch_valid_drop", ifetch_valid, 1'b0);
    if (spur && rv >= 2) begin
      alu_done = 1'b1; dmem_rvalid = 1'b1;
    end
    for (int i = 1; i < rv; i++) begin
      @(negedge clk);
      alu_done = 1'b0; dmem_rvalid = 1'b0;
    end
    mem_enable   = (kind == 1 || kind == 2 || kind >= 5);
    mem_is_store = (kind == 2 || kind == 5);
    reg_write_en = rw;
    alu_multi    = (kind == 3);
    is_ebreak    = (kind == 4);
    ifetch_rvalid = 1'b1;
    #1 chk("ir_we", ir_we, 1'b1);
    if (kind <= 3) begin
      pc_c = next_start + len - 1;
      sb.push_back('{cyc: pc_c, rf: rw, ret: model_ret});
      model_ret++;
      next_start = pc_c + 1;
    end
    @(negedge clk);
    ifetch_rvalid = 1'b0;
    if (kind == 3) begin
      wait_out(2, "alu_start");
      for (int i = 0; i < nmul; i++) begin
        @(negedge clk);
        chk("alu_start_single", alu_start, 1'b0);
      end
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
    end else if (kind == 4) begin
      chk("halted_in_decode", halted, 1'b0);
      @(negedge clk);
      chk("halted", halted, 1'b1);
      chk("pc_we_on_ebreak", pc_we, 1'b0);
    end else if (kind == 5) begin
      wait_out(1, "dmem_req");
      n = 0;
      while (dmem_valid === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("wd_mem_req_cycles", n, TO);
      chk("bus_err", bus_err, 1'b1);
      chk("dmem_valid_dropped", dmem_valid, 1'b0);
      repeat (5) @(negedge clk);
      chk("bus_err_sticky", {bus_err, ifetch_valid}, 2'b10);
    end else if (kind != 0) begin
      wait_out(1, "dmem_req");
      chk("dmem_we", dmem_we, mem_is_store);
      for (int i = 0; i < mr; i++) begin
        @(negedge clk);
        chk("dmem_valid_held", {dmem_valid, dmem_we}, {1'b1, mem_is_store});
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      chk("dmem_valid_drop", dmem_valid, 1'b0);
      if (kind == 6) begin
        do_reset();
      end else begin
        for (int i = 1; i < mv; i++) @(negedge clk);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    wait_out(0, "next_fetch");
    chk("sb_empty", sb.size(), 0);
    chk("retired", retired, model_ret);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int n;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 3; i++) run_instr(0, 1'b1, 0, 1, 0, 0, 0, 1'b0);
    drain();

    run_instr(1, 1'b1, 4, 1, 4, 1, 0, 1'b0);
    run_instr(2, 1'b0, 4, 1, 4, 1, 0, 1'b0);
    drain();

    run_instr(3, 1'b1, 0, 2, 0, 0, 33, 1'b1);
    drain();

    for (int i = 0; i < 25; i++) begin
      run_instr($urandom_range(3, 0), 1'($urandom_range(1, 0)), $urandom_range(5, 0),
                $urandom_range(5, 1), $urandom_range(6, 0), $urandom_range(6, 1),
                $urandom_range(10, 1), 1'($urandom_range(1, 0)));
    end
    drain();

    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_instr($urandom_range(3, 0), 1'b1, $urandom_range(3, 0), $urandom_range(3, 1),
                $urandom_range(3, 0), $urandom_range(3, 1), $urandom_range(5, 1), 1'b0);
    end
    run_instr(4, 1'b0, 0, 1, 0, 0, 0, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifetch_valid) n++;
    end
    chk("no_fetch_after_halt", n, 0);
    chk("retired_at_halt", retired, 64'd3);
    chk("halted_sticky", halted, 1'b1);

    do_reset();
    run_instr(5, 1'b0, 0, 1, 0, 0, 0, 1'b0);

    do_reset();
    run_instr(1, 1'b1, 0, 1, TO - 1, 1, 0, 1'b0);
    drain();
    chk("no_bus_err_at_limit", bus_err, 1'b0);

    do_reset();
    run_instr(6, 1'b1, 0, 1, 0, 1, 0, 1'b0);
    run_instr(0, 1'b1, 0, 1, 0, 0, 0, 1'b0);
    drain();
    chk("retired_after_abort", retired, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
